mux_4x1_rr_arbiter: RTL and testbench
=====================================

# mux_4x1_rr_arbiter

Round-robin arbiter that shares one 4-to-1 single-bit mux datapath between four requesters. It samples four request lines, issues a one-hot grant, and drives the mux select pair (`sel_1`, `sel_0`) so that the granted requester's input reaches the mux output. An optional hold limit stops one requester from monopolising the mux. It sits directly in front of the 4:1 mux instances in the datapath and is their only select source.

## Interface
- `HOLD_MAX`, default 4: maximum consecutive grant cycles for one requester while others wait (hold-limit build only); legal range 2..8.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  synchronous reset, active-low; sampled on `clk` rising edge.
- `req`  input  4  `req[i]` high while requester i wants the mux; held until granted and for the whole transfer.
- `grant`  output  4  one-hot (or zero) grant, registered.
- `sel_1`  output  1  mux select MSB, registered; equals bit 1 of the granted index.
- `sel_0`  output  1  mux select LSB, registered; equals bit 0 of the granted index.
- `busy`  output  1  high while any grant is active.
- `preempt`  output  1  one-cycle pulse when a grant is removed by the hold limit.

## Operation
- States: IDLE (no grant) and GRANT (exactly one `grant` bit high).
- Round-robin pointer `ptr` (2 bits) = highest-priority index; search order ptr, ptr+1, ptr+2, ptr+3 mod 4 (wraps 3->0).
- IDLE: if any `req` high, grant first requester in search order -> GRANT; else stay IDLE.
- GRANT, current grantee g:
  - `req[g]` low: release; in the same edge grant next requester in order starting at g+1, or go IDLE if none. `ptr` <= g+1.
  - `req[g]` high, hold limit reached (`hold_cnt == HOLD_MAX-1`) and another `req` high: grant next requester after g; `preempt` pulses; `ptr` <= g+1.
  - Otherwise keep grant; `hold_cnt` increments, saturating at `HOLD_MAX-1`.
- `hold_cnt` clears to 0 on every new grant (including re-grant after IDLE).
- `{sel_1, sel_0}` updates with every new grant to the granted index. In IDLE it holds its last value and is not cleared.
- `busy` = |`grant`, registered together with `grant`.
- Requests not already granted that rise and fall while others are granted are simply missed. No request latching.

## Timing
- Reset (`rst_n` low at an edge): `grant`=0000, `sel_1`=0, `sel_0`=0, `busy`=0, `preempt`=0, `ptr`=0, `hold_cnt`=0, state IDLE. Reset overrides everything, including mid-grant.
- Grant latency: `req` sampled high at edge N yields `grant`/`sel` valid after edge N (visible in cycle N+1).
- Handoff has no dead cycle. Grantee drops `req` at edge N, and the next grantee is visible after edge N.
- Dropping `req` and another requester rising at the same edge: the new requester is considered in that same arbitration.
- Hold limit: a grantee with waiting competitors holds at most `HOLD_MAX` cycles. `preempt` is high for exactly the first cycle of the new grant.
- A single requester with no competitor is never preempted.

## Configuration
- `ARB_HOLD_LIMIT_EN` defined: hold-limit preemption, `hold_cnt`, and `preempt` behave as above.
- Not defined: no preemption. A grant persists until the grantee drops `req`. `preempt` is tied to 0. `hold_cnt` logic is removed and `HOLD_MAX` is ignored.

## Test plan
- Reset: drive `rst_n`=0 for 2 cycles with `req`=1111 -> `grant`=0000, `{sel_1,sel_0}`=00, `busy`=0. Release `rst_n` -> next cycle `grant`=0001, sel=00.
- Single request: `req`=0100 -> `grant`=0100, sel=10, `busy`=1. Drop `req` -> `grant`=0000, sel stays 10.
- Rotation: `req`=1111, each grantee drops `req` after 1 cycle then re-raises it -> grant order 0001, 0010, 0100, 1000, 0001 with sels 00, 01, 10, 11, 00.
- Wrap: `ptr`=3 after a grant to 2 is released, `req`=1001 -> `grant`=1000 first, then 0001.
- Hold limit (macro on, `HOLD_MAX`=4): `req`=0011 held constant -> `grant`=0001 for 4 cycles, then 0010 with `preempt`=1 for 1 cycle, then 0001 after 4 more. Macro off -> `grant` stays 0001, `preempt`=0.
- Reset mid-grant: `grant`=1000 active, `rst_n`=0 for 1 edge -> all outputs zero. After release with `req`=1010 -> `grant`=0010 (`ptr` reset to 0).

Source files
------------

// File: rtl/mux_4x1_rr_arbiter.sv
// mux_4x1_rr_arbiter: round-robin arbiter driving the select pair of a shared
// 4:1 single-bit mux. Grant, select, busy and preempt are all registered.
// Optional hold-limit preemption is enabled by defining ARB_HOLD_LIMIT_EN;
// without it a grant lasts until the grantee drops its request.
module mux_4x1_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic       sel_1,
  output logic       sel_0,
  output logic       busy,
  output logic       preempt
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 3;

  typedef enum logic {IDLE, GRANT} state_t;

  // Reject hold limits outside the supported range at elaboration
  if (HOLD_MAX < 2 || HOLD_MAX > 8) begin : g_hold_max_check
    $error("HOLD_MAX must be in 2..8");
  end

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   cur;
  logic [IDX_W-1:0]   base;
  logic [N_REQ-1:0]   cand;
  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;

  // First set bit of r in circular order starting at base: {found, index}
  function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                             input logic [IDX_W-1:0] b);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] idx;
    res = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = b + IDX_W'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign cur = {sel_1, sel_0};

  // Candidate set and search start: from ptr when idle, after the grantee otherwise
  always_comb begin
    base = ptr;
    cand = req;
    if (state == GRANT) begin
      base = cur + IDX_W'(1);
      cand = req & ~grant;
    end
    {pick_vld, pick_idx} = rr_pick(cand, base);
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  logic [CNT_W-1:0] hold_cnt;
`else
  assign preempt = 1'b0;
`endif

  // Arbitration state, pointer, grant and select registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
      grant <= '0;
      sel_1 <= 1'b0;
      sel_0 <= 1'b0;
      busy  <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      preempt  <= 1'b0;
      hold_cnt <= '0;
`endif
    end else begin
`ifdef ARB_HOLD_LIMIT_EN
      preempt <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state          <= GRANT;
            grant          <= N_REQ'(1) << pick_idx;
            {sel_1, sel_0} <= pick_idx;
            busy           <= 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
            hold_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          if (!req[cur]) begin
            ptr <= cur + IDX_W'(1);
            if (pick_vld) begin
              grant          <= N_REQ'(1) << pick_idx;
              {sel_1, sel_0} <= pick_idx;
`ifdef ARB_HOLD_LIMIT_EN
              hold_cnt <= '0;
`endif
            end else begin
              state <= IDLE;
              grant <= '0;
              busy  <= 1'b0;
            end
          end
`ifdef ARB_HOLD_LIMIT_EN
          else if (hold_cnt == HOLD_LAST && pick_vld) begin
            ptr            <= cur + IDX_W'(1);
            grant          <= N_REQ'(1) << pick_idx;
            {sel_1, sel_0} <= pick_idx;
            preempt        <= 1'b1;
            hold_cnt       <= '0;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_4x1_rr_arbiter.sv
// Directed bench for mux_4x1_rr_arbiter: each step drives req/rst_n, pushes
// the expected registered outputs to a scoreboard queue, and pops/compares
// them one edge later. Hold-limit expectations follow ARB_HOLD_LIMIT_EN.
module tb_mux_4x1_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic       sel_1;
  logic       sel_0;
  logic       busy;
  logic       preempt;

  int total;
  int bad;

  // {grant[3:0], sel[1:0], busy, preempt}
  logic [7:0] exp_q[$];

  mux_4x1_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .grant   (grant),
    .sel_1   (sel_1),
    .sel_0   (sel_0),
    .busy    (busy),
    .preempt (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic rst_v, input logic [3:0] r,
                      input logic [3:0] eg, input logic [1:0] es,
                      input logic ep, input string tag);
    logic [7:0] e;
    @(negedge clk);
    rst_n = rst_v;
    req   = r;
    exp_q.push_back({eg, es, |eg, ep});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    total++;
    assert (grant === e[7:4]) else begin
      bad++;
      $error("FAIL %s grant: got %b want %b", tag, grant, e[7:4]);
    end
    total++;
    assert ({sel_1, sel_0} === e[3:2]) else begin
      bad++;
      $error("FAIL %s sel: got %b want %b", tag, {sel_1, sel_0}, e[3:2]);
    end
    total++;
    assert (busy === e[1]) else begin
      bad++;
      $error("FAIL %s busy: got %b want %b", tag, busy, e[1]);
    end
    total++;
    assert (preempt === e[0]) else begin
      bad++;
      $error("FAIL %s preempt: got %b want %b", tag, preempt, e[0]);
    end
  endtask

  initial begin
    logic [3:0] eg;
    logic       ep;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 4'b0000;

    // Reset with all requests pending, then release
    step(1'b0, 4'b1111, 4'b0000, 2'b00, 1'b0, "rst1");
    step(1'b0, 4'b1111, 4'b0000, 2'b00, 1'b0, "rst2");
    step(1'b1, 4'b1111, 4'b0001, 2'b00, 1'b0, "rst_rel");

    // Rotation: each grantee drops for one cycle
    step(1'b1, 4'b1110, 4'b0010, 2'b01, 1'b0, "rot1");
    step(1'b1, 4'b1101, 4'b0100, 2'b10, 1'b0, "rot2");
    step(1'b1, 4'b1011, 4'b1000, 2'b11, 1'b0, "rot3");
    step(1'b1, 4'b0111, 4'b0001, 2'b00, 1'b0, "rot4");

    // Single request; select holds across idle
    step(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, "idle0");
    step(1'b1, 4'b0100, 4'b0100, 2'b10, 1'b0, "single");
    step(1'b1, 4'b0100, 4'b0100, 2'b10, 1'b0, "single_hold");
    step(1'b1, 4'b0000, 4'b0000, 2'b10, 1'b0, "sel_keep");

    // Wrap: ptr is 3 after releasing requester 2
    step(1'b1, 4'b1001, 4'b1000, 2'b11, 1'b0, "wrap3");
    step(1'b1, 4'b1001, 4'b1000, 2'b11, 1'b0, "wrap3_hold");
    step(1'b1, 4'b0001, 4'b0001, 2'b00, 1'b0, "wrap0");

    // Handoff where the new requester rises on the release edge
    step(1'b1, 4'b0011, 4'b0001, 2'b00, 1'b0, "ho_a");
    step(1'b1, 4'b0010, 4'b0010, 2'b01, 1'b0, "ho_b");
    step(1'b1, 4'b0100, 4'b0100, 2'b10, 1'b0, "ho_rise");
    step(1'b1, 4'b0000, 4'b0000, 2'b10, 1'b0, "ho_idle");

    // Hold limit from a fresh reset, two requesters held constant
    step(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, "rst_h");
    for (int i = 0; i < 10; i++) begin
`ifdef ARB_HOLD_LIMIT_EN
      eg = (i < 4 || i >= 8) ? 4'b0001 : 4'b0010;
      ep = (i == 4 || i == 8);
`else
      eg = 4'b0001;
      ep = 1'b0;
`endif
      step(1'b1, 4'b0011, eg, (eg == 4'b0010) ? 2'b01 : 2'b00, ep, "hold");
    end

    // Reset in the middle of a grant to requester 3
    step(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, "rst_m0");
    step(1'b1, 4'b1000, 4'b1000, 2'b11, 1'b0, "mid_g3");
    step(1'b0, 4'b1010, 4'b0000, 2'b00, 1'b0, "rst_mid");
    step(1'b1, 4'b1010, 4'b0010, 2'b01, 1'b0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
